fll_ctrl: RTL and testbench
===========================

Name: fll_ctrl

Overview:
- Next-generation frequency-locked-loop controller for the LC-DCO, running entirely in the `ref_clk` domain.
- Each measurement window lasts a programmable number of reference cycles. During the window, the block counts rising edges of the divided DCO clock.
- It compares the count against a programmable target and reports a signed frequency error.
- It applies saturating, step-sized corrections to an internal DCO control code, and asserts a lock flag with separate acquire and release hysteresis.

Parameters:
- `CNT_W`, 10: width of the window counter, target count, measured count and lock range.
- `CODE_W`, 6: width of the DCO control code and the step size.
- `LOCK_WINDOWS`, 3: number of consecutive in-range windows required to assert lock.
- `UNLOCK_WINDOWS`, 2: number of consecutive out-of-range windows required to drop lock.

Ports:
- `ref_clk`  in  1  reference clock; the block's only clock.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  run request; 0 forces IDLE.
- `dco_divclk`  in  1  divided DCO clock; asynchronous to `ref_clk`, sampled as data.
- `win_len`  in  `CNT_W`  window length in `ref_clk` cycles; 0 is treated as 1.
- `target_cnt`  in  `CNT_W`  expected `dco_divclk` rising edges per window.
- `lock_range`  in  `CNT_W`  in-range tolerance; in range when |freq_err| <= `lock_range`.
- `step_size`  in  `CODE_W`  correction magnitude applied per update.
- `code_init`  in  `CODE_W`  DCO code loaded on reset and on entry to MEASURE from IDLE.
- `meas_cnt`  out  `CNT_W`  edge count from the last completed window.
- `freq_err`  out  `CNT_W`+1  signed, two's complement; equals `target_cnt` - `meas_cnt`.
- `freq_update`  out  1  single-cycle pulse when a correction is applied.
- `freq_incr_decr`  out  1  correction direction: 1 = increase, 0 = decrease; valid with `freq_update`, held otherwise.
- `dco_code`  out  `CODE_W`  current DCO control code.
- `fll_locked`  out  1  lock status.

Behaviour:
- Reset values (`reset`=0 at a clock edge):
  - FSM goes to IDLE; all counters, synchronisers and the in-range/out-of-range run counters are cleared.
  - `meas_cnt`, `freq_err`, `freq_update`, `freq_incr_decr` and `fll_locked` are all 0.
  - `dco_code` = `code_init`.
- Input sampling:
  - `dco_divclk` passes through a 2-flop synchroniser plus one history flop.
  - A rising edge is counted when sync[1]=1 and hist=0, giving a 3-cycle sampling latency.
  - Correct operation requires `dco_divclk` high and low phases of at least 2 `ref_clk` cycles each.
- State machine: IDLE -> MEASURE -> EVAL -> UPDATE -> MEASURE.
- IDLE:
  - Outputs hold and `fll_locked` = 0.
  - When `enable`=1: load `dco_code` <= `code_init`, clear the window and edge counters, go to MEASURE.
- MEASURE:
  - The window counter increments every cycle, and the edge counter increments on each detected edge.
  - The edge counter saturates at 2^`CNT_W`-1.
  - On the cycle where window counter == max(`win_len`,1)-1, any edge detected in that cycle is still counted, and the FSM goes to EVAL.
- EVAL (1 cycle):
  - `meas_cnt` <= edge count.
  - `freq_err` <= zero-extended `target_cnt` minus zero-extended edge count, computed at `CNT_W`+1 bits.
- UPDATE (1 cycle):
  - In range: no pulse; out-of-range run <= 0; in-range run increments, saturating at `LOCK_WINDOWS`. `fll_locked` <= 1 when the incremented run equals `LOCK_WINDOWS`.
  - Out of range: `freq_update`=1 for this cycle; `freq_incr_decr` <= (`freq_err` > 0).
    - `dco_code` moves by ±`step_size`, clamped to [0, 2^`CODE_W`-1].
    - In-range run <= 0; out-of-range run increments, saturating.
    - `fll_locked` <= 0 when the out-of-range run reaches `UNLOCK_WINDOWS`.
  - Corrections continue while locked.
  - Clears the window and edge counters, then returns to MEASURE.
- Dead time: edges detected during EVAL and UPDATE are not counted. The loop period is max(`win_len`,1)+2 cycles.
- Inputs `win_len`, `target_cnt`, `lock_range` and `step_size` are sampled when used; changes mid-window take effect immediately.
- `enable`=0 in any non-IDLE state:
  - Next state is IDLE and `fll_locked` <= 0.
  - Run counters are cleared, no `freq_update` pulse is issued, and `dco_code` holds.
- `reset` has priority over `enable`.

Test Plan:
- Reset: `reset`=0 for 4 cycles with `code_init`=32 -> all outputs 0 except `dco_code`=32; no `freq_update` pulse for 10 cycles with `enable`=0.
- Lock acquire: `dco_divclk` period 8, `win_len`=256, `target_cnt`=32, `lock_range`=1 -> `meas_cnt` in {31,32,33}, no `freq_update` pulse, `fll_locked`=1 in the UPDATE cycle of window 3 (cycle 3×258 after enable plus FSM entry).
- Correction: `dco_divclk` period 10, otherwise as above, `step_size`=1 -> `meas_cnt` in {25,26}, `freq_err`=+7/+6, one `freq_update` pulse per window with `freq_incr_decr`=1, `dco_code` 32->33->34.
- Saturation:
  - `code_init`=62, `step_size`=4, slow DCO -> `dco_code`=63 and stays at 63.
  - `code_init`=2, fast DCO (period 6, `target_cnt`=32) -> `dco_code`=0 and stays at 0, with `freq_incr_decr`=0.
- Unlock hysteresis: lock reached, then one out-of-range window -> `fll_locked` stays 1; a second consecutive window -> 0; an in-range window in between resets the count.
- Abort: deassert `enable` at window cycle 100 -> IDLE next cycle, `fll_locked`=0, no pulse, `dco_code` held. Re-enable -> `dco_code` reloads `code_init` and the window restarts from 0.

Source files
------------

// File: rtl/fll_ctrl.sv
// fll_ctrl: frequency-locked-loop controller for the LC-DCO, ref_clk domain only.
// Counts rising edges of the divided DCO clock over a programmable window,
// reports the signed error against a target count, moves the DCO code by a
// saturating step when out of range, and tracks lock with separate
// acquire/release hysteresis.
//
// Ports:
//   ref_clk, reset        clock; synchronous active-low reset
//   enable                run request; low parks the loop in IDLE
//   dco_divclk            divided DCO clock (asynchronous, sampled as data)
//   win_len               window length in ref_clk cycles (0 acts as 1)
//   target_cnt            expected edges per window
//   lock_range            in range when |freq_err| <= lock_range
//   step_size, code_init  correction magnitude; code loaded on start
//   meas_cnt, freq_err    last window edge count; target - count (signed)
//   freq_update           one-cycle pulse per applied correction
//   freq_incr_decr        direction of the last correction (1 = up)
//   dco_code, fll_locked  DCO control code; lock status
module fll_ctrl #(
  parameter int CNT_W          = 10,
  parameter int CODE_W         = 6,
  parameter int LOCK_WINDOWS   = 3,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dco_divclk,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic [CNT_W-1:0]  lock_range,
  input  logic [CODE_W-1:0] step_size,
  input  logic [CODE_W-1:0] code_init,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic [CNT_W:0]    freq_err,
  output logic              freq_update,
  output logic              freq_incr_decr,
  output logic [CODE_W-1:0] dco_code,
  output logic              fll_locked
);
  localparam int LRUN_W = $clog2(LOCK_WINDOWS + 1);
  localparam int URUN_W = $clog2(UNLOCK_WINDOWS + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, EVAL, UPDATE} state_t;
  state_t state, state_nxt;

  logic [1:0]        sync;
  logic              hist;
  logic              rise;
  logic [CNT_W-1:0]  win_cnt, edge_cnt, win_last;
  logic [CNT_W:0]    err_mag;
  logic              in_range, err_pos;
  logic [CODE_W:0]   code_up;
  logic [CODE_W-1:0] code_nxt;
  logic [LRUN_W-1:0] in_run, in_run_inc;
  logic [URUN_W-1:0] out_run, out_run_inc;

  // sync[1] & ~hist: one-cycle strobe per rising edge, 3 cycles after the pin
  assign rise     = sync[1] & ~hist;
  assign win_last = (win_len == '0) ? '0 : win_len - CNT_W'(1);

  // |freq_err| always fits CNT_W bits since both operands were unsigned CNT_W
  assign err_mag  = freq_err[CNT_W] ? ('0 - freq_err) : freq_err;
  assign in_range = (err_mag <= {1'b0, lock_range});
  assign err_pos  = ~freq_err[CNT_W] && (freq_err != '0);

  assign code_up  = {1'b0, dco_code} + {1'b0, step_size};

  always_comb begin
    code_nxt = dco_code;
    if (err_pos) code_nxt = code_up[CODE_W] ? '1 : code_up[CODE_W-1:0];
    else         code_nxt = (step_size > dco_code) ? '0 : dco_code - step_size;
  end

  assign in_run_inc  = (in_run == LRUN_W'(LOCK_WINDOWS)) ? in_run : in_run + LRUN_W'(1);
  assign out_run_inc = (out_run == URUN_W'(UNLOCK_WINDOWS)) ? out_run : out_run + URUN_W'(1);

  always_ff @(posedge ref_clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = MEASURE;
      // >= rather than == so a window shortened mid-flight still closes
      MEASURE: if (win_cnt >= win_last) state_nxt = EVAL;
      EVAL:    state_nxt = UPDATE;
      UPDATE:  state_nxt = MEASURE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      sync           <= '0;
      hist           <= 1'b0;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      meas_cnt       <= '0;
      freq_err       <= '0;
      freq_update    <= 1'b0;
      freq_incr_decr <= 1'b0;
      dco_code       <= code_init;
      fll_locked     <= 1'b0;
      in_run         <= '0;
      out_run        <= '0;
    end else begin
      sync        <= {sync[0], dco_divclk};
      hist        <= sync[1];
      freq_update <= 1'b0;
      if (!enable) begin
        // abort: drop lock and history, keep the code where it is
        fll_locked <= 1'b0;
        in_run     <= '0;
        out_run    <= '0;
      end else begin
        case (state)
          IDLE: begin
            dco_code <= code_init;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end
          MEASURE: begin
            win_cnt <= win_cnt + CNT_W'(1);
            if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + CNT_W'(1);
          end
          EVAL: begin
            meas_cnt <= edge_cnt;
            freq_err <= {1'b0, target_cnt} - {1'b0, edge_cnt};
          end
          UPDATE: begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            if (in_range) begin
              out_run <= '0;
              in_run  <= in_run_inc;
              if (in_run_inc == LRUN_W'(LOCK_WINDOWS)) fll_locked <= 1'b1;
            end else begin
              freq_update    <= 1'b1;
              freq_incr_decr <= err_pos;
              dco_code       <= code_nxt;
              in_run         <= '0;
              out_run        <= out_run_inc;
              if (out_run_inc == URUN_W'(UNLOCK_WINDOWS)) fll_locked <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fll_ctrl.sv
`timescale 1ns/1ps
module tb_fll_ctrl;
  localparam int CNT_W    = 10;
  localparam int CODE_W   = 6;
  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;
  localparam int CODE_MAX = (1 << CODE_W) - 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int HMAX     = 1 << 17;

  logic              ref_clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              dco_divclk = 1'b0;
  logic [CNT_W-1:0]  win_len = '0;
  logic [CNT_W-1:0]  target_cnt = '0;
  logic [CNT_W-1:0]  lock_range = '0;
  logic [CODE_W-1:0] step_size = '0;
  logic [CODE_W-1:0] code_init = '0;
  logic [CNT_W-1:0]  meas_cnt;
  logic [CNT_W:0]    freq_err;
  logic              freq_update;
  logic              freq_incr_decr;
  logic [CODE_W-1:0] dco_code;
  logic              fll_locked;

  fll_ctrl #(.CNT_W(CNT_W), .CODE_W(CODE_W), .LOCK_WINDOWS(LOCK_N),
             .UNLOCK_WINDOWS(UNLOCK_N)) dut (
    .ref_clk(ref_clk), .reset(reset), .enable(enable), .dco_divclk(dco_divclk),
    .win_len(win_len), .target_cnt(target_cnt), .lock_range(lock_range),
    .step_size(step_size), .code_init(code_init), .meas_cnt(meas_cnt),
    .freq_err(freq_err), .freq_update(freq_update),
    .freq_incr_decr(freq_incr_decr), .dco_code(dco_code), .fll_locked(fll_locked)
  );

  always #5 ref_clk = ~ref_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  bit vhist [HMAX];

  // cyc = index of the latest posedge; vhist[k] = pin value seen at posedge k
  always @(posedge ref_clk) begin
    cyc = cyc + 1;
    if (cyc < HMAX) vhist[cyc] = dco_divclk;
    if (freq_update === 1'b1) pulses = pulses + 1;
  end

  // DCO stimulus: fixed half period, or random halves of 2..6 cycles
  int dco_half = 0;
  bit dco_jit = 1'b0;
  int ph = 0;
  int cur_half = 4;
  always @(negedge ref_clk) begin
    if (dco_half == 0 && !dco_jit) begin
      dco_divclk = 1'b0; ph = 0; cur_half = 4;
    end else begin
      ph = ph + 1;
      if (ph >= cur_half) begin
        dco_divclk = ~dco_divclk;
        ph = 0;
        cur_half = dco_jit ? int'($urandom_range(2, 6)) : dco_half;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // reference model state
  int wstart, wlen;
  int m_code, m_in, m_out, m_cnt, m_err, m_pulses;
  bit m_locked, m_upd, m_dir;

  // rising edges the loop should see in MEASURE posedges first..last
  function automatic int count_edges(input int first, input int last);
    int n = 0;
    for (int p = first; p <= last; p++)
      if (p >= 3 && vhist[p-2] && !vhist[p-3]) n++;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // wait for the end of the current window's UPDATE and advance the model
  task automatic step_window();
    int tgt, stp, mag;
    wlen = (win_len == '0) ? 1 : int'(win_len);
    tgt = wstart + wlen + 2;
    while (cyc < tgt) @(negedge ref_clk);
    m_cnt = count_edges(wstart + 1, wstart + wlen);
    m_err = int'(target_cnt) - m_cnt;
    mag = (m_err < 0) ? -m_err : m_err;
    m_upd = (mag > int'(lock_range));
    stp = int'(step_size);
    if (!m_upd) begin
      m_out = 0;
      if (m_in < LOCK_N) m_in++;
      if (m_in == LOCK_N) m_locked = 1'b1;
    end else begin
      m_dir = (m_err > 0);
      m_code = m_dir ? ((m_code + stp > CODE_MAX) ? CODE_MAX : m_code + stp)
                     : ((m_code - stp < 0) ? 0 : m_code - stp);
      m_in = 0;
      if (m_out < UNLOCK_N) m_out++;
      if (m_out == UNLOCK_N) m_locked = 1'b0;
      m_pulses++;
    end
    wstart = tgt;
  endtask

  task automatic do_reset(input int ci);
    @(negedge ref_clk);
    enable = 1'b0; reset = 1'b0; dco_half = 0; dco_jit = 1'b0;
    code_init = CODE_W'(ci);
    repeat (4) @(negedge ref_clk);
    reset = 1'b1;
    m_code = ci; m_in = 0; m_out = 0; m_locked = 1'b0;
    m_cnt = 0; m_err = 0; m_dir = 1'b0; m_upd = 1'b0;
    repeat (4) @(negedge ref_clk);
  endtask

  task automatic start_run();
    repeat ($urandom_range(0, 7)) @(negedge ref_clk);
    enable = 1'b1;
    wstart = cyc + 1;
    m_code = int'(code_init); m_in = 0; m_out = 0; m_locked = 1'b0;
  endtask

  task automatic set_loop(input int wl, input int tg, input int lr, input int st);
    win_len = CNT_W'(wl); target_cnt = CNT_W'(tg);
    lock_range = CNT_W'(lr); step_size = CODE_W'(st);
  endtask

  task automatic test_reset();
    int p0;
    @(negedge ref_clk);
    enable = 1'b0; reset = 1'b0; code_init = 6'd32; dco_half = 0;
    set_loop(256, 32, 1, 1);
    repeat (4) @(negedge ref_clk);
    checks++; if (meas_cnt !== '0) begin failures++; $display("FAIL rst_meas: got %0d expected 0", meas_cnt); end
    checks++; if (freq_err !== '0) begin failures++; $display("FAIL rst_err: got %0d expected 0", freq_err); end
    checks++; if (freq_update !== 1'b0) begin failures++; $display("FAIL rst_upd: got %b expected 0", freq_update); end
    checks++; if (freq_incr_decr !== 1'b0) begin failures++; $display("FAIL rst_dir: got %b expected 0", freq_incr_decr); end
    checks++; if (fll_locked !== 1'b0) begin failures++; $display("FAIL rst_lock: got %b expected 0", fll_locked); end
    checks++; if (dco_code !== 6'd32) begin failures++; $display("FAIL rst_code: got %0d expected 32", dco_code); end
    reset = 1'b1;
    m_code = 32; m_in = 0; m_out = 0; m_locked = 1'b0; m_dir = 1'b0;
    dco_half = 4;
    p0 = pulses;
    repeat (10) @(negedge ref_clk);
    checks++; if (pulses != p0) begin failures++; $display("FAIL idle_pulse: got %0d expected 0", pulses - p0); end
    checks++; if (dco_code !== 6'd32) begin failures++; $display("FAIL idle_code: got %0d expected 32", dco_code); end
  endtask

  task automatic test_lock_acquire();
    int p0;
    do_reset(32);
    set_loop(256, 32, 1, 1);
    dco_half = 4;
    repeat (20) @(negedge ref_clk);
    p0 = pulses;
    start_run();
    for (int n = 0; n < 4; n++) begin
      step_window();
      checks++;
      if (meas_cnt !== CNT_W'(m_cnt) || meas_cnt < 31 || meas_cnt > 33) begin
        failures++; $display("FAIL lock_meas w%0d: got %0d expected %0d", n, meas_cnt, m_cnt);
      end
      checks++;
      if (fll_locked !== (n >= 2) || fll_locked !== m_locked) begin
        failures++; $display("FAIL lock_flag w%0d: got %b expected %b", n, fll_locked, n >= 2);
      end
      checks++; if (freq_update !== 1'b0) begin failures++; $display("FAIL lock_upd w%0d: got %b expected 0", n, freq_update); end
    end
    @(negedge ref_clk);
    checks++; if (pulses != p0) begin failures++; $display("FAIL lock_pulses: got %0d expected 0", pulses - p0); end
  endtask

  // runs on from the locked state left by test_lock_acquire
  task automatic test_unlock_hysteresis();
    int p0, mp0;
    bit exp_lock [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int halves [4] = '{5, 4, 5, 5};
    lock_range = CNT_W'(2);
    p0 = pulses; mp0 = m_pulses;
    for (int n = 0; n < 4; n++) begin
      dco_half = halves[n];
      step_window();
      checks++;
      if (fll_locked !== exp_lock[n] || fll_locked !== m_locked) begin
        failures++; $display("FAIL unlock_flag w%0d: got %b expected %b", n, fll_locked, exp_lock[n]);
      end
      checks++;
      if (freq_update !== (halves[n] == 5)) begin
        failures++; $display("FAIL unlock_upd w%0d: got %b expected %b", n, freq_update, halves[n] == 5);
      end
      checks++; if (dco_code !== CODE_W'(m_code)) begin failures++; $display("FAIL unlock_code w%0d: got %0d expected %0d", n, dco_code, m_code); end
    end
    @(negedge ref_clk);
    checks++;
    if (pulses - p0 != 3 || m_pulses - mp0 != 3) begin
      failures++; $display("FAIL unlock_pulses: got %0d expected 3", pulses - p0);
    end
  endtask

  task automatic test_correction();
    do_reset(32);
    set_loop(256, 32, 1, 1);
    dco_half = 5;
    repeat (20) @(negedge ref_clk);
    start_run();
    for (int n = 0; n < 3; n++) begin
      step_window();
      checks++;
      if (meas_cnt !== CNT_W'(m_cnt) || meas_cnt < 25 || meas_cnt > 26) begin
        failures++; $display("FAIL corr_meas w%0d: got %0d expected %0d", n, meas_cnt, m_cnt);
      end
      checks++;
      if (freq_err !== (CNT_W+1)'(m_err) || m_err < 6 || m_err > 7) begin
        failures++; $display("FAIL corr_err w%0d: got %0d expected %0d", n, $signed(freq_err), m_err);
      end
      checks++; if (freq_update !== 1'b1) begin failures++; $display("FAIL corr_upd w%0d: got %b expected 1", n, freq_update); end
      checks++; if (freq_incr_decr !== 1'b1) begin failures++; $display("FAIL corr_dir w%0d: got %b expected 1", n, freq_incr_decr); end
      checks++; if (dco_code !== CODE_W'(33 + n)) begin failures++; $display("FAIL corr_code w%0d: got %0d expected %0d", n, dco_code, 33 + n); end
      @(negedge ref_clk);
      checks++; if (freq_update !== 1'b0) begin failures++; $display("FAIL corr_pulse_w w%0d: got %b expected 0", n, freq_update); end
    end
  endtask

  task automatic test_saturation();
    do_reset(62);
    set_loop(64, 32, 1, 4);
    dco_half = 5;
    repeat (20) @(negedge ref_clk);
    start_run();
    for (int n = 0; n < 3; n++) begin
      step_window();
      checks++;
      if (dco_code !== 6'd63 || dco_code !== CODE_W'(m_code)) begin
        failures++; $display("FAIL sat_hi w%0d: got %0d expected 63", n, dco_code);
      end
    end
    do_reset(2);
    set_loop(256, 32, 1, 1);
    dco_half = 3;
    repeat (20) @(negedge ref_clk);
    start_run();
    for (int n = 0; n < 4; n++) begin
      step_window();
      checks++;
      if (dco_code !== CODE_W'((n >= 1) ? 0 : 1) || dco_code !== CODE_W'(m_code)) begin
        failures++; $display("FAIL sat_lo w%0d: got %0d expected %0d", n, dco_code, (n >= 1) ? 0 : 1);
      end
      checks++; if (freq_incr_decr !== 1'b0) begin failures++; $display("FAIL sat_lo_dir w%0d: got %b expected 0", n, freq_incr_decr); end
    end
  endtask

  task automatic test_abort();
    int p0;
    do_reset(20);
    set_loop(256, 32, 2, 1);
    dco_half = 5;
    repeat (20) @(negedge ref_clk);
    start_run();
    step_window();
    dco_half = 4;
    repeat (3) step_window();
    checks++;
    if (fll_locked !== 1'b1 || dco_code !== 6'd21 || m_code != 21) begin
      failures++; $display("FAIL abort_pre: got lock=%b code=%0d expected lock=1 code=21", fll_locked, dco_code);
    end
    while (cyc < wstart + 100) @(negedge ref_clk);
    enable = 1'b0;
    m_in = 0; m_out = 0; m_locked = 1'b0;
    p0 = pulses;
    @(negedge ref_clk);
    checks++; if (fll_locked !== 1'b0) begin failures++; $display("FAIL abort_lock: got %b expected 0", fll_locked); end
    checks++; if (freq_update !== 1'b0) begin failures++; $display("FAIL abort_upd: got %b expected 0", freq_update); end
    code_init = 6'd40;
    dco_half = 5;
    repeat (6) @(negedge ref_clk);
    checks++; if (dco_code !== 6'd21) begin failures++; $display("FAIL abort_hold: got %0d expected 21", dco_code); end
    checks++; if (pulses != p0) begin failures++; $display("FAIL abort_pulse: got %0d expected 0", pulses - p0); end
    start_run();
    @(negedge ref_clk);
    checks++; if (dco_code !== 6'd40) begin failures++; $display("FAIL reen_code: got %0d expected 40", dco_code); end
    step_window();
    checks++; if (pulses != p0) begin failures++; $display("FAIL reen_early: got %0d expected 0", pulses - p0); end
    checks++; if (freq_update !== 1'b1) begin failures++; $display("FAIL reen_upd: got %b expected 1", freq_update); end
    checks++; if (meas_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL reen_meas: got %0d expected %0d", meas_cnt, m_cnt); end
    checks++; if (dco_code !== 6'd41) begin failures++; $display("FAIL reen_code2: got %0d expected 41", dco_code); end
  endtask

  task automatic test_random();
    int p0, mp0;
    do_reset(int'($urandom_range(0, CODE_MAX)));
    dco_jit = 1'b1;
    set_loop(int'($urandom_range(1, 60)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    repeat (20) @(negedge ref_clk);
    p0 = pulses; mp0 = m_pulses;
    start_run();
    for (int n = 0; n < 40; n++) begin
      step_window();
      checks++; if (meas_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rnd_meas w%0d: got %0d expected %0d", n, meas_cnt, m_cnt); end
      checks++; if (freq_err !== (CNT_W+1)'(m_err)) begin failures++; $display("FAIL rnd_err w%0d: got %0d expected %0d", n, $signed(freq_err), m_err); end
      checks++; if (freq_update !== m_upd) begin failures++; $display("FAIL rnd_upd w%0d: got %b expected %b", n, freq_update, m_upd); end
      checks++; if (freq_incr_decr !== m_dir) begin failures++; $display("FAIL rnd_dir w%0d: got %b expected %b", n, freq_incr_decr, m_dir); end
      checks++; if (dco_code !== CODE_W'(m_code)) begin failures++; $display("FAIL rnd_code w%0d: got %0d expected %0d", n, dco_code, m_code); end
      checks++; if (fll_locked !== m_locked) begin failures++; $display("FAIL rnd_lock w%0d: got %b expected %b", n, fll_locked, m_locked); end
      set_loop(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 60)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
    @(negedge ref_clk);
    checks++;
    if (pulses - p0 != m_pulses - mp0) begin
      failures++; $display("FAIL rnd_pulses: got %0d expected %0d", pulses - p0, m_pulses - mp0);
    end
  endtask

  initial begin
    m_pulses = 0;
    test_reset();
    test_lock_acquire();
    test_unlock_hysteresis();
    test_correction();
    test_saturation();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
